timer_sequencer: RTL and testbench

Periodic measurement sequencer that drives an external 16-bit down-counter timer (preset/enable/zero interface). It times the sampling period and starts a sensor measurement when the period expires. It then reuses the same counter as a watchdog while waiting for the sensor's ready signal and reports completion or timeout to the CPU. It sits between the parameter registers and a shared down-counter cell in the sensor-node subsystem.

---
 rtl/timer_sequencer.sv | 121 ++++++++++++
 tb/tb_timer_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sequencer.sv
// Periodic sensor sequencer: times the sample period and the sensor watchdog on a shared external down-counter.
// Pulses/flags are registered (one cycle after the causing edge); timer controls are combinational; no backpressure.
module timer_sequencer #(
    parameter int Width      = 16,
    parameter int CountWidth = 8
) (
    input  logic                  Clk_i,
    input  logic                  Reset_n_i,
    input  logic                  Enable_i,
    input  logic [Width-1:0]      ParamPeriod_i,
    input  logic [Width-1:0]      ParamTimeout_i,
    output logic                  SensorStart_o,
    input  logic                  SensorReady_i,
    output logic                  TimerPreset_o,
    output logic                  TimerEnable_o,
    output logic [Width-1:0]      TimerPresetVal_o,
    input  logic                  TimerZero_i,
    output logic                  CpuIntr_o,
    output logic                  Timeout_o,
    output logic [CountWidth-1:0] MeasCount_o
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_PERIOD = 2'd1,
        MEASURE     = 2'd2,
        ERROR       = 2'd3
    } state_t;

    localparam logic [CountWidth-1:0] CountOne = {{(CountWidth-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic                  sensor_start_q, sensor_start_d;
    logic                  cpu_intr_q, cpu_intr_d;
    logic                  timeout_q, timeout_d;
    logic [CountWidth-1:0] meas_count_q, meas_count_d;

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q        <= IDLE;
            sensor_start_q <= 1'b0;
            cpu_intr_q     <= 1'b0;
            timeout_q      <= 1'b0;
            meas_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            sensor_start_q <= sensor_start_d;
            cpu_intr_q     <= cpu_intr_d;
            timeout_q      <= timeout_d;
            meas_count_q   <= meas_count_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        sensor_start_d   = 1'b0;
        cpu_intr_d       = 1'b0;
        timeout_d        = timeout_q;
        meas_count_d     = meas_count_q;
        TimerPreset_o    = 1'b0;
        TimerEnable_o    = 1'b0;
        TimerPresetVal_o = ParamPeriod_i;

        unique case (state_q)
            IDLE: begin
                // Keep the counter primed with the period so WAIT_PERIOD starts counting at once.
                TimerPreset_o = 1'b1;
                if (Enable_i) begin
                    state_d      = WAIT_PERIOD;
                    timeout_d    = 1'b0;
                    meas_count_d = '0;
                end
            end
            WAIT_PERIOD: begin
                TimerEnable_o = 1'b1;
                if (TimerZero_i) begin
                    TimerPreset_o    = 1'b1;
                    TimerPresetVal_o = ParamTimeout_i;
                    state_d          = MEASURE;
                    sensor_start_d   = 1'b1;
                end
            end
            MEASURE: begin
                TimerEnable_o = 1'b1;
                if (SensorReady_i || TimerZero_i) begin
                    TimerPreset_o = 1'b1;
                end
                // Ready on the zero cycle still counts as a successful measurement.
                if (SensorReady_i) begin
                    state_d      = WAIT_PERIOD;
                    cpu_intr_d   = 1'b1;
                    meas_count_d = meas_count_q + CountOne;
                end else if (TimerZero_i) begin
                    state_d   = ERROR;
                    timeout_d = 1'b1;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Dropping the run request aborts everything; status registers keep their values.
        if (!Enable_i) begin
            state_d        = IDLE;
            sensor_start_d = 1'b0;
            cpu_intr_d     = 1'b0;
            timeout_d      = timeout_q;
            meas_count_d   = meas_count_q;
        end
    end

    assign SensorStart_o = sensor_start_q;
    assign CpuIntr_o     = cpu_intr_q;
    assign Timeout_o     = timeout_q;
    assign MeasCount_o   = meas_count_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: models the external down-counter and a sensor with a fixed answer delay,
// and predicts pulse timing from the period/timeout/delay arithmetic.
module tb_timer_sequencer;
    localparam int W  = 16;
    localparam int CW = 8;

    logic          Clk_i = 1'b0;
    logic          Reset_n_i;
    logic          Enable_i;
    logic [W-1:0]  ParamPeriod_i;
    logic [W-1:0]  ParamTimeout_i;
    logic          SensorStart_o;
    logic          SensorReady_i;
    logic          TimerPreset_o;
    logic          TimerEnable_o;
    logic [W-1:0]  TimerPresetVal_o;
    logic          TimerZero_i;
    logic          CpuIntr_o;
    logic          Timeout_o;
    logic [CW-1:0] MeasCount_o;

    always #5 Clk_i = ~Clk_i;

    timer_sequencer #(.Width(W), .CountWidth(CW)) dut (
        .Clk_i            (Clk_i),
        .Reset_n_i        (Reset_n_i),
        .Enable_i         (Enable_i),
        .ParamPeriod_i    (ParamPeriod_i),
        .ParamTimeout_i   (ParamTimeout_i),
        .SensorStart_o    (SensorStart_o),
        .SensorReady_i    (SensorReady_i),
        .TimerPreset_o    (TimerPreset_o),
        .TimerEnable_o    (TimerEnable_o),
        .TimerPresetVal_o (TimerPresetVal_o),
        .TimerZero_i      (TimerZero_i),
        .CpuIntr_o        (CpuIntr_o),
        .Timeout_o        (Timeout_o),
        .MeasCount_o      (MeasCount_o)
    );

    // External down-counter cell
    logic [W-1:0] cnt;
    always @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i)         cnt <= '0;
        else if (TimerPreset_o) cnt <= TimerPresetVal_o;
        else if (TimerEnable_o) cnt <= cnt - 1'b1;
    end
    assign TimerZero_i = (cnt == '0);

    int cyc = 0;
    always @(posedge Clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int got_start[$];
    int got_intr[$];
    int exp_start[$];
    int exp_intr[$];
    int got_to, exp_to, e0;
    bit act;
    int idx;
    int sens_d;

    // One clock: sample outputs at the falling edge, then drive the sensor answer for this cycle.
    task automatic run_cycle();
        @(negedge Clk_i);
        if (SensorStart_o) got_start.push_back(cyc);
        if (CpuIntr_o) got_intr.push_back(cyc);
        if (Timeout_o && got_to < 0) got_to = cyc;
        if (SensorStart_o) begin
            act = 1'b1;
            idx = 0;
        end else if (act) begin
            idx++;
        end
        SensorReady_i = act && (idx == sens_d);
        if (SensorReady_i) act = 1'b0;
    endtask

    task automatic start_scn(input int p, input int t, input int d);
        Enable_i       = 1'b0;
        ParamPeriod_i  = W'(p);
        ParamTimeout_i = W'(t);
        sens_d         = d;
        act            = 1'b0;
        SensorReady_i  = 1'b0;
        run_cycle();
        act           = 1'b0;
        SensorReady_i = 1'b0;
        got_start.delete();
        got_intr.delete();
        got_to   = -1;
        Enable_i = 1'b1;
        e0       = cyc + 1;
    endtask

    // Entry into WAIT at edge e: start seen in cycle e+P+1 (= m). Success if the sensor
    // delay D <= T: interrupt in cycle m+D+1, which is also the next WAIT entry.
    // Otherwise the timeout flag appears in cycle m+T+1 and the sequence stops.
    task automatic gen_exp(input int p, input int t, input int d, input int last);
        int e, m;
        exp_start.delete();
        exp_intr.delete();
        exp_to = -1;
        e = e0;
        forever begin
            m = e + p + 1;
            if (m > last) break;
            exp_start.push_back(m);
            if (d <= t) begin
                if (m + d + 1 > last) break;
                exp_intr.push_back(m + d + 1);
                e = m + d + 1;
            end else begin
                if (m + t + 1 <= last) exp_to = m + t + 1;
                break;
            end
        end
    endtask

    task automatic test_sequence(input string name, input int p, input int t, input int d, input int n);
        start_scn(p, t, d);
        repeat (n) run_cycle();
        gen_exp(p, t, d, cyc);
        checks++;
        if (got_start.size() !== exp_start.size())
            begin errors++; $display("FAIL %s start_count: got %0d expected %0d", name, got_start.size(), exp_start.size()); end
        for (int i = 0; i < got_start.size() && i < exp_start.size(); i++) begin
            checks++;
            if (got_start[i] !== exp_start[i])
                begin errors++; $display("FAIL %s start[%0d]: got cycle %0d expected %0d", name, i, got_start[i] - e0, exp_start[i] - e0); end
        end
        checks++;
        if (got_intr.size() !== exp_intr.size())
            begin errors++; $display("FAIL %s intr_count: got %0d expected %0d", name, got_intr.size(), exp_intr.size()); end
        for (int i = 0; i < got_intr.size() && i < exp_intr.size(); i++) begin
            checks++;
            if (got_intr[i] !== exp_intr[i])
                begin errors++; $display("FAIL %s intr[%0d]: got cycle %0d expected %0d", name, i, got_intr[i] - e0, exp_intr[i] - e0); end
        end
        checks++;
        if (got_to !== exp_to)
            begin errors++; $display("FAIL %s timeout_cycle: got %0d expected %0d", name, got_to, exp_to); end
        checks++;
        if (MeasCount_o !== CW'(exp_intr.size()))
            begin errors++; $display("FAIL %s meas_count: got %0d expected %0d", name, MeasCount_o, CW'(exp_intr.size())); end
    endtask

    task automatic test_reset();
        Reset_n_i      = 1'b0;
        Enable_i       = 1'b0;
        SensorReady_i  = 1'b0;
        ParamPeriod_i  = 16'h1234;
        ParamTimeout_i = 16'h0055;
        act            = 1'b0;
        sens_d         = 0;
        got_to         = -1;
        repeat (3) @(negedge Clk_i);
        checks++;
        if ({SensorStart_o, CpuIntr_o, Timeout_o, MeasCount_o} !== '0)
            begin errors++; $display("FAIL reset_regs: got %b/%b/%b/%0d expected 0/0/0/0", SensorStart_o, CpuIntr_o, Timeout_o, MeasCount_o); end
        checks++;
        if (TimerPreset_o !== 1'b1 || TimerEnable_o !== 1'b0 || TimerPresetVal_o !== 16'h1234)
            begin errors++; $display("FAIL reset_timer: got pre=%b en=%b val=%h expected 1 0 1234", TimerPreset_o, TimerEnable_o, TimerPresetVal_o); end
        Reset_n_i = 1'b1;
        run_cycle();
    endtask

    task automatic test_timeout();
        test_sequence("timeout", 4, 6, 255, 30);
        checks++;
        if (Timeout_o !== 1'b1 || TimerEnable_o !== 1'b0 || TimerPreset_o !== 1'b0)
            begin errors++; $display("FAIL error_state: got to=%b en=%b pre=%b expected 1 0 0", Timeout_o, TimerEnable_o, TimerPreset_o); end
        Enable_i = 1'b0;
        run_cycle();
        checks++;
        if (Timeout_o !== 1'b1)
            begin errors++; $display("FAIL timeout_hold_idle: got %b expected 1", Timeout_o); end
        Enable_i = 1'b1;
        run_cycle();
        checks++;
        if (Timeout_o !== 1'b0)
            begin errors++; $display("FAIL timeout_clear: got %b expected 0", Timeout_o); end
    endtask

    task automatic test_enable_drop();
        start_scn(2, 10, 1);
        repeat (14) run_cycle();
        checks++;
        if (SensorStart_o !== 1'b1 || MeasCount_o !== 8'd2)
            begin errors++; $display("FAIL drop_setup: got start=%b count=%0d expected 1 2", SensorStart_o, MeasCount_o); end
        Enable_i = 1'b0;
        run_cycle();
        checks++;
        if (TimerPreset_o !== 1'b1 || TimerEnable_o !== 1'b0 || TimerPresetVal_o !== 16'd2)
            begin errors++; $display("FAIL drop_timer: got pre=%b en=%b val=%0d expected 1 0 2", TimerPreset_o, TimerEnable_o, TimerPresetVal_o); end
        checks++;
        if (SensorStart_o !== 1'b0 || CpuIntr_o !== 1'b0 || MeasCount_o !== 8'd2)
            begin errors++; $display("FAIL drop_outputs: got start=%b intr=%b count=%0d expected 0 0 2", SensorStart_o, CpuIntr_o, MeasCount_o); end
        repeat (3) run_cycle();
        checks++;
        if (got_intr.size() !== 2 || MeasCount_o !== 8'd2)
            begin errors++; $display("FAIL drop_hold: got intr=%0d count=%0d expected 2 2", got_intr.size(), MeasCount_o); end
        Enable_i = 1'b1;
        run_cycle();
        checks++;
        if (MeasCount_o !== 8'd0)
            begin errors++; $display("FAIL drop_reenable_clear: got %0d expected 0", MeasCount_o); end
    endtask

    task automatic test_wrap();
        start_scn(0, 0, 0);
        repeat (511) run_cycle();
        checks++;
        if (got_start.size() == 0 || got_start[0] !== e0 + 1)
            begin errors++; $display("FAIL wrap_first_start: got %0d entries first %0d expected cycle %0d", got_start.size(), got_start.size() ? got_start[0] - e0 : -1, 1); end
        gen_exp(0, 0, 0, cyc);
        checks++;
        if (MeasCount_o !== CW'(exp_intr.size()) || exp_intr.size() != 255)
            begin errors++; $display("FAIL wrap_count_255: got %0d expected %0d", MeasCount_o, CW'(exp_intr.size())); end
        repeat (2) run_cycle();
        gen_exp(0, 0, 0, cyc);
        checks++;
        if (MeasCount_o !== 8'd0 || got_intr.size() !== exp_intr.size())
            begin errors++; $display("FAIL wrap_to_zero: got count=%0d intr=%0d expected 0 %0d", MeasCount_o, got_intr.size(), exp_intr.size()); end
        checks++;
        if (Timeout_o !== 1'b0)
            begin errors++; $display("FAIL wrap_timeout: got %b expected 0", Timeout_o); end
    endtask

    task automatic test_async_reset();
        start_scn(1, 5, 0);
        repeat (7) run_cycle();
        checks++;
        if (CpuIntr_o !== 1'b1 || MeasCount_o !== 8'd2 || TimerEnable_o !== 1'b1)
            begin errors++; $display("FAIL areset_setup: got intr=%b count=%0d en=%b expected 1 2 1", CpuIntr_o, MeasCount_o, TimerEnable_o); end
        #2 Reset_n_i = 1'b0;
        #1;
        checks++;
        if ({SensorStart_o, CpuIntr_o, Timeout_o, MeasCount_o} !== '0 || TimerEnable_o !== 1'b0 || TimerPreset_o !== 1'b1)
            begin errors++; $display("FAIL areset_immediate: got st=%b intr=%b to=%b cnt=%0d en=%b pre=%b expected 0 0 0 0 0 1",
                                     SensorStart_o, CpuIntr_o, Timeout_o, MeasCount_o, TimerEnable_o, TimerPreset_o); end
        @(negedge Clk_i);
        Reset_n_i = 1'b1;
        act = 1'b0;
        SensorReady_i = 1'b0;
        #1;
        checks++;
        if (TimerPreset_o !== 1'b1 || TimerPresetVal_o !== 16'd1 || TimerEnable_o !== 1'b0)
            begin errors++; $display("FAIL areset_release: got pre=%b val=%0d en=%b expected 1 1 0", TimerPreset_o, TimerPresetVal_o, TimerEnable_o); end
        run_cycle();
        checks++;
        if (TimerEnable_o !== 1'b1)
            begin errors++; $display("FAIL areset_restart: got en=%b expected 1", TimerEnable_o); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            int p, t, d;
            p = $urandom_range(0, 7);
            t = $urandom_range(0, 7);
            d = $urandom_range(0, 9);
            test_sequence("random", p, t, d, 70);
        end
    endtask

    initial begin
        test_reset();
        test_sequence("basic", 5, 10, 3, 60);
        test_timeout();
        test_sequence("ready_at_zero", 2, 3, 3, 40);
        test_enable_drop();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got no end expected end");
        $fatal(1, "watchdog expired");
    end

endmodule
